pop_arbiter_out: RTL

POP_ARBITER_OUT -- requirements
Module: pop_arbiter_out

---
 rtl/pop_arbiter_out.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pop_arbiter_out.sv
// ---------------------------------------------------------------------------
// pop_arbiter_out
//
// Round-robin pop arbiter between two upstream FIFOs (D0, D1) feeding a
// 2-entry output buffer. Pop requests are registered; the FIFO read data
// arrives while the pop request is high and is captured into the buffer
// tail at the end of that cycle. The buffer head is presented downstream
// with a valid/ready handshake, and every delivered word is counted per
// source.
//
// Ports
//   clk            in   1  sole clock, rising edge
//   reset          in   1  synchronous, active-low reset
//   data_out_D0    in   6  read data from D0 FIFO
//   data_out_D1    in   6  read data from D1 FIFO
//   empty_fifo_D0  in   1  D0 FIFO empty flag
//   empty_fifo_D1  in   1  D1 FIFO empty flag
//   ready_in       in   1  downstream accepts data_out this cycle
//   D0_pop         out  1  registered pop request to D0 FIFO
//   D1_pop         out  1  registered pop request to D1 FIFO
//   data_out       out  6  word presented downstream (buffer head)
//   valid_out      out  1  data_out holds a word
//   src_out        out  1  source of data_out (0 = D0, 1 = D1)
//   count_D0       out  5  words delivered from D0, wrapping
//   count_D1       out  5  words delivered from D1, wrapping
// ---------------------------------------------------------------------------
module pop_arbiter_out (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] data_out_D0,
    input  logic [5:0] data_out_D1,
    input  logic       empty_fifo_D0,
    input  logic       empty_fifo_D1,
    input  logic       ready_in,
    output logic       D0_pop,
    output logic       D1_pop,
    output logic [5:0] data_out,
    output logic       valid_out,
    output logic       src_out,
    output logic [4:0] count_D0,
    output logic [4:0] count_D1
);

    typedef enum logic {
        PRIO_D0 = 1'b0,
        PRIO_D1 = 1'b1
    } prio_t;

    prio_t      prio;
    prio_t      prio_next;

    logic [5:0] buf_data [2];
    logic       buf_src  [2];
    logic [1:0] occupancy;

    logic       in_flight;
    logic       transfer;
    logic       room;
    logic       wr_idx;
    logic [2:0] committed;
    logic [5:0] cap_data;
    logic       cap_src;
    logic       pop_d0_next;
    logic       pop_d1_next;

    // A pop request that is high this cycle has its data on the FIFO read
    // port now, so it is captured at the coming edge.
    assign in_flight = D0_pop | D1_pop;
    assign cap_src   = D1_pop;
    assign cap_data  = D1_pop ? data_out_D1 : data_out_D0;

    assign valid_out = (occupancy != 2'd0);
    assign transfer  = valid_out & ready_in;
    assign data_out  = buf_data[0];
    assign src_out   = buf_src[0];

    // Words that will sit in the buffer after the coming edge. A new pop is
    // only safe when that leaves a free slot for its data one edge later.
    // transfer implies occupancy >= 1, so this never underflows.
    assign committed = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, transfer};
    assign room      = (committed < 3'd2);

    // Tail slot for the captured word, accounting for a same-cycle shift of
    // the head out of the buffer.
    assign wr_idx = transfer ? (occupancy == 2'd2) : (occupancy != 2'd0);

    // Round-robin choice: with both sources ready the one named by prio wins
    // and prio flips; with one source ready it wins and prio points at the
    // other, so the idle source gets the next tie.
    always_comb begin
        pop_d0_next = 1'b0;
        pop_d1_next = 1'b0;
        prio_next   = prio;
        if (room) begin
            if (!empty_fifo_D0 && !empty_fifo_D1) begin
                if (prio == PRIO_D0) begin
                    pop_d0_next = 1'b1;
                    prio_next   = PRIO_D1;
                end else begin
                    pop_d1_next = 1'b1;
                    prio_next   = PRIO_D0;
                end
            end else if (!empty_fifo_D0) begin
                pop_d0_next = 1'b1;
                prio_next   = PRIO_D1;
            end else if (!empty_fifo_D1) begin
                pop_d1_next = 1'b1;
                prio_next   = PRIO_D0;
            end
        end
    end

    // Buffer, counters and pop registers. The shift of the head and the tail
    // write are ordered so a simultaneous capture and transfer lands in the
    // slot freed by the shift, keeping arrival order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            D0_pop      <= 1'b0;
            D1_pop      <= 1'b0;
            prio        <= PRIO_D0;
            occupancy   <= 2'd0;
            buf_data[0] <= 6'd0;
            buf_data[1] <= 6'd0;
            buf_src[0]  <= 1'b0;
            buf_src[1]  <= 1'b0;
            count_D0    <= 5'd0;
            count_D1    <= 5'd0;
        end else begin
            D0_pop    <= pop_d0_next;
            D1_pop    <= pop_d1_next;
            prio      <= prio_next;
            occupancy <= occupancy + {1'b0, in_flight} - {1'b0, transfer};

            if (transfer) begin
                buf_data[0] <= buf_data[1];
                buf_src[0]  <= buf_src[1];
                if (src_out) begin
                    count_D1 <= count_D1 + 5'd1;
                end else begin
                    count_D0 <= count_D0 + 5'd1;
                end
            end

            if (in_flight) begin
                buf_data[wr_idx] <= cap_data;
                buf_src[wr_idx]  <= cap_src;
            end
        end
    end

endmodule
